// File: rtl/bbox_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bbox_pkg
// Purpose  : Shared types and constants for the bounding-box crop/scale path:
//            the box descriptor, the crop FSM state encoding, the default
//            image/patch geometry and a helper that unpacks the 32-bit box.
// Revision : 1.0  initial release
// ============================================================================
package bbox_pkg;

  localparam int c_IMG_W   = 100;
  localparam int c_IMG_H   = 100;
  localparam int c_OUT_DIM = 28;

  typedef struct packed {
    logic [7:0] x_min;
    logic [7:0] x_max;
    logic [7:0] y_min;
    logic [7:0] y_max;
  } box_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DIV  = 3'd1,
    ST_ADDR = 3'd2,
    ST_READ = 3'd3,
    ST_OUT  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Box word layout: xMin[31:24], xMax[23:16], yMin[15:8], yMax[7:0]
  function automatic box_t unpack_box(input logic [31:0] raw);
    box_t b;
    b.x_min = raw[31:24];
    b.x_max = raw[23:16];
    b.y_min = raw[15:8];
    b.y_max = raw[7:0];
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bbox_span_div.sv
`default_nettype none
// ============================================================================
// Module   : bbox_span_div
// Purpose  : Serial restoring 8-bit unsigned divider. One quotient bit per
//            cycle; results are valid on the cycle done pulses (9 cycles
//            after the accepted start). start is ignored while dividing.
// Ports    : CLOCK_50, reset_n (sync, active-low)
//            start      in   begin a division of dividend by divisor
//            dividend   in   8-bit numerator
//            divisor    in   8-bit denominator (non-zero)
//            done       out  one-cycle pulse, quotient/remainder valid
//            quotient   out  8-bit quotient
//            remainder  out  8-bit remainder
// Revision : 1.0  initial release
// ============================================================================
module bbox_span_div
  import bbox_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder
);

  logic       r_busy;
  logic       r_done;
  logic [3:0] r_cnt;
  logic [7:0] r_quo;
  logic [7:0] r_rem;

  logic [8:0] w_shift;
  logic       w_fits;
  logic [7:0] w_diff;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign w_shift = {r_rem, r_quo[7]};
  assign w_fits  = (w_shift >= {1'b0, divisor});
  // When the divisor fits the true difference is below the divisor, so the
  // low byte of the wrapped subtraction is exact.
  assign w_diff  = w_shift[7:0] - divisor;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= 4'd0;
      r_quo  <= 8'd0;
      r_rem  <= 8'd0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_rem <= w_fits ? w_diff : w_shift[7:0];
        r_quo <= {r_quo[6:0], w_fits};
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == 4'd7) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (start) begin
        r_busy <= 1'b1;
        r_cnt  <= 4'd0;
        r_quo  <= dividend;
        r_rem  <= 8'd0;
      end
    end
  end

  assign done      = r_done;
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/bbox_crop_scaler.sv
`default_nettype none
// ============================================================================
// Module   : bbox_crop_scaler
// Purpose  : Crops the detected bounding box from the pixel RAM and rescales
//            it by nearest-neighbour sampling to an OUT_DIM x OUT_DIM patch,
//            streamed in raster order over valid/ready.
// Ports    : CLOCK_50, reset_n (sync, active-low)
//            start, box_in        box request (xMin,xMax,yMin,yMax)
//            busy, done, err      status
//            mem_addr, mem_rd     pixel RAM read request
//            mem_rddata           RAM data, one cycle after mem_rd
//            out_valid/out_ready  patch stream handshake
//            out_data, out_last   sampled pixel, final-pixel marker
// Revision : 1.0  initial release
// ============================================================================
module bbox_crop_scaler
  import bbox_pkg::*;
#(
  parameter int IMG_W   = c_IMG_W,
  parameter int IMG_H   = c_IMG_H,
  parameter int OUT_DIM = c_OUT_DIM,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 15
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       box_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [PIX_W-1:0]  mem_rddata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_data,
  output logic              out_last
);

  localparam logic [7:0] c_DIM  = 8'(OUT_DIM);
  localparam logic [7:0] c_LAST = 8'(OUT_DIM - 1);

  state_t r_state, w_next_state;

  box_t             w_box_in;
  logic             w_in_invalid;
  logic [7:0]       w_span_w_in, w_span_h_in;

  logic             r_err;
  logic             r_div_y;       // 0: x span division running, 1: y span
  logic [7:0]       r_x_min, r_y_min, r_span_h;
  logic [7:0]       r_qx, r_rx, r_qy, r_ry;
  logic [7:0]       r_offx, r_remx, r_offy, r_remy;
  logic [7:0]       r_col, r_row;
  logic [PIX_W-1:0] r_out_data;

  logic             w_div_start, w_div_done;
  logic [7:0]       w_div_dividend, w_div_quo, w_div_rem;

  logic [7:0]       w_sumx, w_sumy;
  logic             w_wrapx, w_wrapy;
  logic             w_last;
  logic [ADDR_W-1:0] w_src_x, w_src_y, w_addr;

  // ---------------------------------------------------------------- input box
  assign w_box_in     = unpack_box(box_in);
  assign w_in_invalid = (w_box_in.x_min > w_box_in.x_max) ||
                        (w_box_in.y_min > w_box_in.y_max) ||
                        (32'(w_box_in.x_max) >= IMG_W)    ||
                        (32'(w_box_in.y_max) >= IMG_H);
  assign w_span_w_in  = w_box_in.x_max - w_box_in.x_min + 8'd1;
  assign w_span_h_in  = w_box_in.y_max - w_box_in.y_min + 8'd1;

  // ------------------------------------------------------------------ divider
  // The x division is kicked off on the accepting start cycle straight from
  // box_in; the y division starts on the cycle the x result appears.
  bbox_span_div u_div (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .start     (w_div_start),
    .dividend  (w_div_dividend),
    .divisor   (c_DIM),
    .done      (w_div_done),
    .quotient  (w_div_quo),
    .remainder (w_div_rem)
  );

  // --------------------------------------------------------------- DDA steps
  // offset tracks floor(k*span/OUT_DIM), remainder tracks k*span mod OUT_DIM.
  assign w_sumx  = r_remx + r_rx;
  assign w_wrapx = (w_sumx >= c_DIM);
  assign w_sumy  = r_remy + r_ry;
  assign w_wrapy = (w_sumy >= c_DIM);
  assign w_last  = (r_col == c_LAST) && (r_row == c_LAST);

  assign w_src_x = ADDR_W'(r_x_min) + ADDR_W'(r_offx);
  assign w_src_y = ADDR_W'(r_y_min) + ADDR_W'(r_offy);
  assign w_addr  = w_src_y * ADDR_W'(IMG_W) + w_src_x;

  // -------------------------------------------------------------- FSM state
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state   = r_state;
    w_div_start    = 1'b0;
    w_div_dividend = r_span_h;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state   = ST_DIV;
          w_div_start    = 1'b1;
          w_div_dividend = w_span_w_in;
        end
      end
      ST_DIV: begin
        if (w_div_done) begin
          if (!r_div_y) w_div_start  = 1'b1;
          else          w_next_state = r_err ? ST_OUT : ST_ADDR;
        end
      end
      ST_ADDR: w_next_state = ST_READ;
      ST_READ: w_next_state = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          if (w_last)     w_next_state = ST_DONE;
          else if (r_err) w_next_state = ST_OUT;
          else            w_next_state = ST_ADDR;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_err      <= 1'b0;
      r_div_y    <= 1'b0;
      r_x_min    <= 8'd0;
      r_y_min    <= 8'd0;
      r_span_h   <= 8'd0;
      r_qx       <= 8'd0;
      r_rx       <= 8'd0;
      r_qy       <= 8'd0;
      r_ry       <= 8'd0;
      r_offx     <= 8'd0;
      r_remx     <= 8'd0;
      r_offy     <= 8'd0;
      r_remy     <= 8'd0;
      r_col      <= 8'd0;
      r_row      <= 8'd0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_err      <= w_in_invalid;
            r_div_y    <= 1'b0;
            r_x_min    <= w_box_in.x_min;
            r_y_min    <= w_box_in.y_min;
            r_span_h   <= w_span_h_in;
            r_offx     <= 8'd0;
            r_remx     <= 8'd0;
            r_offy     <= 8'd0;
            r_remy     <= 8'd0;
            r_col      <= 8'd0;
            r_row      <= 8'd0;
            r_out_data <= '0;
          end
        end
        ST_DIV: begin
          if (w_div_done) begin
            if (!r_div_y) begin
              r_qx    <= w_div_quo;
              r_rx    <= w_div_rem;
              r_div_y <= 1'b1;
            end else begin
              r_qy <= w_div_quo;
              r_ry <= w_div_rem;
            end
          end
        end
        ST_READ: r_out_data <= mem_rddata;
        ST_OUT: begin
          if (out_ready) begin
            if (r_col == c_LAST) begin
              // Row end: column DDA restarts, row DDA steps once.
              r_col  <= 8'd0;
              r_offx <= 8'd0;
              r_remx <= 8'd0;
              r_row  <= r_row + 8'd1;
              r_offy <= r_offy + r_qy + {7'd0, w_wrapy};
              r_remy <= w_wrapy ? (w_sumy - c_DIM) : w_sumy;
            end else begin
              r_col  <= r_col + 8'd1;
              r_offx <= r_offx + r_qx + {7'd0, w_wrapx};
              r_remx <= w_wrapx ? (w_sumx - c_DIM) : w_sumx;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ----------------------------------------------------------------- outputs
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign err       = r_err;
  assign mem_rd    = (r_state == ST_ADDR);
  assign mem_addr  = (r_state == ST_ADDR) ? w_addr : '0;
  assign out_valid = (r_state == ST_OUT);
  assign out_data  = r_out_data;
  assign out_last  = (r_state == ST_OUT) && w_last;

endmodule
`default_nettype wire

// File: tb/tb_bbox_crop_scaler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bbox_crop_scaler
// Purpose  : Self-checking bench for bbox_crop_scaler. A behavioural pixel
//            RAM answers reads; expected patches come from direct arithmetic
//            on the box (floor(i*w/OUT_DIM) sampling).
// Revision : 1.0  initial release
// ============================================================================
module tb_bbox_crop_scaler;

  localparam int IMG_W   = 100;
  localparam int IMG_H   = 100;
  localparam int OUT_DIM = 28;
  localparam int PIX_W   = 8;
  localparam int ADDR_W  = 15;
  localparam int NPIX    = OUT_DIM * OUT_DIM;

  logic              CLOCK_50 = 1'b0;
  logic              reset_n  = 1'b0;
  logic              start    = 1'b0;
  logic [31:0]       box_in   = 32'd0;
  logic              busy, done, err, mem_rd, out_valid, out_last;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rddata = '0;
  logic              out_ready  = 1'b0;
  logic [PIX_W-1:0]  out_data;

  logic [7:0] ram  [0:(1<<ADDR_W)-1];
  logic [7:0] cap  [0:NPIX-1];
  logic [7:0] cap1 [0:NPIX-1];

  int errors = 0;
  int checks = 0;
  int g_rdn, g_rmin, g_rmax;

  bbox_crop_scaler #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_DIM(OUT_DIM), .PIX_W(PIX_W), .ADDR_W(ADDR_W)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .start     (start),
    .box_in    (box_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rddata(mem_rddata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Pixel RAM: data one cycle after the read strobe, garbage otherwise.
  always @(posedge CLOCK_50)
    mem_rddata <= mem_rd ? ram[mem_addr] : 8'($urandom);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit box_bad(input int x0, input int x1, input int y0, input int y1);
    return (x0 > x1) || (y0 > y1) || (x1 >= IMG_W) || (y1 >= IMG_H);
  endfunction

  // Nearest-neighbour reference: pixel k of the patch in raster order.
  function automatic logic [7:0] ref_pix(input int x0, input int x1, input int y0,
                                         input int y1, input int k);
    int w, h, sx, sy;
    if (box_bad(x0, x1, y0, y1)) return 8'h00;
    w  = x1 - x0 + 1;
    h  = y1 - y0 + 1;
    sx = x0 + ((k % OUT_DIM) * w) / OUT_DIM;
    sy = y0 + ((k / OUT_DIM) * h) / OUT_DIM;
    return ram[sy * IMG_W + sx];
  endfunction

  task automatic run_box(input string tag, input int x0, input int x1, input int y0,
                         input int y1, input bit stall, input bit inject);
    bit inv, held;
    int k, cyc, lat, last_cyc;
    logic [7:0] hd;
    logic hl;
    inv    = box_bad(x0, x1, y0, y1);
    box_in = {8'(x0), 8'(x1), 8'(y0), 8'(y1)};
    start  = 1'b1;
    out_ready = 1'b0;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    chk({tag, "/busy_after_start"}, busy, 1);
    chk({tag, "/err"}, err, inv);
    k = 0; cyc = 1; lat = -1; last_cyc = 0; held = 0;
    g_rdn = 0; g_rmin = 1 << 30; g_rmax = -1;
    while (k < NPIX && cyc < 20000) begin
      if (mem_rd) begin
        g_rdn++;
        if (int'(mem_addr) < g_rmin) g_rmin = int'(mem_addr);
        if (int'(mem_addr) > g_rmax) g_rmax = int'(mem_addr);
      end
      if (inject && cyc == 50) begin
        box_in = 32'h00_05_00_05;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (held) begin
        chk({tag, "/stall_valid"}, out_valid, 1);
        chk({tag, "/stall_data"}, out_data, hd);
        chk({tag, "/stall_last"}, out_last, hl);
      end
      held = 0;
      if (out_valid) begin
        if (lat < 0) lat = cyc;
        if (out_ready) begin
          chk({tag, "/pix"}, out_data, ref_pix(x0, x1, y0, y1, k));
          chk({tag, "/last"}, out_last, (k == NPIX - 1));
          cap[k]   = out_data;
          last_cyc = cyc;
          k++;
        end else begin
          held = 1;
          hd   = out_data;
          hl   = out_last;
        end
      end
      @(posedge CLOCK_50); #1;
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    chk({tag, "/pixel_count"}, k, NPIX);
    chk({tag, "/done_pulse"}, done, 1);
    chk({tag, "/busy_in_done"}, busy, 1);
    chk({tag, "/valid_after_last"}, out_valid, 0);
    chk({tag, "/first_valid_latency"}, lat, inv ? 19 : 21);
    if (!stall)
      chk({tag, "/throughput"}, last_cyc - lat, inv ? NPIX - 1 : 3 * (NPIX - 1));
    chk({tag, "/reads"}, g_rdn, inv ? 0 : NPIX);
    if (!inv) begin
      chk({tag, "/addr_min_in_box"}, g_rmin >= y0 * IMG_W + x0, 1);
      chk({tag, "/addr_max_in_box"}, g_rmax <= y1 * IMG_W + x1, 1);
    end
    @(posedge CLOCK_50); #1;
    chk({tag, "/done_one_cycle"}, done, 0);
    chk({tag, "/idle_busy"}, busy, 0);
  endtask

  initial begin
    int diffs, dn, rx0, rx1, ry0, ry1;

    for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = 8'(a);

    // Reset state
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("reset/busy", busy, 0);
    chk("reset/done", done, 0);
    chk("reset/err", err, 0);
    chk("reset/mem_rd", mem_rd, 0);
    chk("reset/mem_addr", mem_addr, 0);
    chk("reset/out_valid", out_valid, 0);
    chk("reset/out_data", out_data, 0);
    chk("reset/out_last", out_last, 0);
    reset_n = 1'b1;
    @(posedge CLOCK_50); #1;

    // Full frame
    run_box("full", 0, 99, 0, 99, 0, 0);
    chk("full/pix_1_1", cap[OUT_DIM + 1], 8'h2F);
    chk("full/pix_27_27", cap[NPIX - 1], 8'hE0);
    for (int k = 0; k < NPIX; k++) cap1[k] = cap[k];

    // Full frame with random back-pressure and a start while busy
    run_box("stall", 0, 99, 0, 99, 1, 1);
    diffs = 0;
    for (int k = 0; k < NPIX; k++) if (cap[k] !== cap1[k]) diffs++;
    chk("stall/same_as_full", diffs, 0);

    // Invalid box
    run_box("invalid", 50, 40, 0, 99, 0, 0);

    // Valid start clears err; reset in mid-frame aborts without done
    box_in = {8'd0, 8'd99, 8'd0, 8'd99};
    start  = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    chk("abort/err_cleared", err, 0);
    out_ready = 1'b1;
    repeat (600) @(posedge CLOCK_50);
    #1;
    chk("abort/busy_before_reset", busy, 1);
    reset_n = 1'b0;
    @(posedge CLOCK_50); #1;
    reset_n = 1'b1;
    chk("abort/busy", busy, 0);
    chk("abort/done", done, 0);
    chk("abort/out_valid", out_valid, 0);
    chk("abort/out_data", out_data, 0);
    chk("abort/out_last", out_last, 0);
    chk("abort/mem_rd", mem_rd, 0);
    chk("abort/mem_addr", mem_addr, 0);
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLOCK_50); #1;
      if (done || busy) dn++;
    end
    chk("abort/no_done_no_busy", dn, 0);
    out_ready = 1'b0;
    run_box("rerun", 0, 99, 0, 99, 0, 0);
    diffs = 0;
    for (int k = 0; k < NPIX; k++) if (cap[k] !== cap1[k]) diffs++;
    chk("rerun/same_as_full", diffs, 0);

    // Random RAM contents from here on
    for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = 8'($urandom);

    // Identity box: exact copy
    run_box("identity", 10, 37, 20, 47, 0, 0);
    diffs = 0;
    for (int k = 0; k < NPIX; k++)
      if (cap[k] !== ram[(20 + k / OUT_DIM) * IMG_W + 10 + k % OUT_DIM]) diffs++;
    chk("identity/copy", diffs, 0);

    // Single pixel box
    run_box("single", 5, 5, 7, 7, 0, 0);
    chk("single/addr_min", g_rmin, 705);
    chk("single/addr_max", g_rmax, 705);
    diffs = 0;
    for (int k = 0; k < NPIX; k++) if (cap[k] !== ram[705]) diffs++;
    chk("single/all_same", diffs, 0);

    // Random valid boxes, including the far image corner
    for (int t = 0; t < 3; t++) begin
      rx0 = $urandom_range(0, IMG_W - 1);
      rx1 = $urandom_range(rx0, IMG_W - 1);
      ry0 = $urandom_range(0, IMG_H - 1);
      ry1 = $urandom_range(ry0, IMG_H - 1);
      if (t == 2) begin rx1 = IMG_W - 1; ry1 = IMG_H - 1; end
      run_box("random", rx0, rx1, ry0, ry1, 1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
